// File: rtl/pdecoder_3to7_accum.sv
// Rebuilds a sparse bit-mask from a stream of set-bit indices and emits the mask
// with its popcount and an ordering/range error flag over a valid/ready output.
module pdecoder_3to7_accum #(
    parameter int MASK_W = 7,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_nz,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MASK_W-1:0] out_mask,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_err
);

    typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

    localparam logic [IDX_W:0]   MASK_W_I = (IDX_W + 1)'(MASK_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MASK_W);

    state_t             state_q;
    logic [MASK_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               first_q;
    logic [IDX_W-1:0]   prev_q;
    logic               out_valid_q;
    logic [MASK_W-1:0]  out_mask_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic               out_err_q;

    logic               in_range;
    logic [MASK_W-1:0]  bit_oh;
    logic               bit_new;

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_cnt   = out_cnt_q;
    assign out_err   = out_err_q;

    // Group state as it would stand after absorbing the current beat.
    always_comb begin
        in_range = ({1'b0, in_idx} < MASK_W_I);
        bit_oh   = '0;
        if (in_nz && in_range) begin
            bit_oh = MASK_W'(1) << in_idx;
        end
        bit_new = |(bit_oh & ~acc_q);
        acc_d   = acc_q | bit_oh;
        cnt_d   = cnt_q;
        if (bit_new && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = err_q
              | (in_nz & ~in_range)
              | (in_nz & ~first_q & (in_idx <= prev_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b1;
            prev_q      <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_cnt_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (in_valid) begin
                        if (in_last) begin
                            out_mask_q  <= acc_d;
                            out_cnt_q   <= cnt_d;
                            out_err_q   <= err_d;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            err_q       <= 1'b0;
                            first_q     <= 1'b1;
                            state_q     <= S_OUT;
                        end else begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_d;
                            err_q <= err_d;
                            if (in_nz) begin
                                first_q <= 1'b0;
                                prev_q  <= in_idx;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_ACC;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_pdecoder_3to7_accum.sv
// Directed bench for pdecoder_3to7_accum: a list-based group model checked every
// cycle, plus hand-computed expectations for each directed group.
module tb_pdecoder_3to7_accum;

    localparam int MASK_W = 7;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  in_idx = '0;
    logic              in_nz = 1'b0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [MASK_W-1:0] out_mask;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_err;

    int checks = 0;
    int errors = 0;

    pdecoder_3to7_accum #(.MASK_W(MASK_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
        .in_nz(in_nz), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_cnt(out_cnt), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remembers the nonzero indices of the open group as a list and
    // derives mask, popcount and error from the whole list when the group closes.
    int          beats[$];
    bit          m_valid = 1'b0;
    logic [6:0]  m_mask = '0;
    int          m_cnt = 0;
    bit          m_err = 1'b0;

    task automatic build_group();
        m_mask = '0;
        m_err  = 1'b0;
        foreach (beats[i]) begin
            if (beats[i] >= MASK_W) m_err = 1'b1;
            else m_mask[beats[i]] = 1'b1;
            if (i > 0 && beats[i] <= beats[i-1]) m_err = 1'b1;
        end
        m_cnt = $countones(m_mask);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats.delete();
            m_valid = 1'b0;
            m_mask  = '0;
            m_cnt   = 0;
            m_err   = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (in_valid) begin
            if (in_nz) beats.push_back(int'(in_idx));
            if (in_last) begin
                build_group();
                m_valid = 1'b1;
                beats.delete();
            end
        end
    end

    always @(negedge clk) begin
        chk("m_in_ready", int'(in_ready), int'(!m_valid));
        chk("m_out_valid", int'(out_valid), int'(m_valid));
        chk("m_out_mask", int'(out_mask), int'(m_mask));
        chk("m_out_cnt", int'(out_cnt), m_cnt);
        chk("m_out_err", int'(out_err), int'(m_err));
        chk("m_popcount", int'(out_cnt), $countones(out_mask));
    end

    task automatic send(int idx, bit nz, bit last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_idx   = idx[IDX_W-1:0];
        in_nz    = nz;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_nz    = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(string name, int exp_mask, int exp_cnt, int exp_err, int hold);
        int n = 0;
        logic [MASK_W-1:0] m0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 0);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_mask"}, int'(out_mask), exp_mask);
        chk({name, "_cnt"}, int'(out_cnt), exp_cnt);
        chk({name, "_err"}, int'(out_err), exp_err);
        m0 = out_mask;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_idx   = 3'd6;
            in_nz    = 1'b1;
            in_last  = 1'b1;
            @(negedge clk);
            chk({name, "_hold_ready"}, int'(in_ready), 0);
            chk({name, "_hold_valid"}, int'(out_valid), 1);
            chk({name, "_hold_mask"}, int'(out_mask), int'(m0));
        end
        in_valid  = 1'b0;
        in_nz     = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_released"}, int'(out_valid), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_mask", int'(out_mask), 0);
        #2 rst_n = 1'b1;

        send(1, 1, 0); send(4, 1, 0); send(6, 1, 1);
        recv("g_146", 7'h52, 3, 0, 0);

        send(0, 0, 1);
        recv("g_empty", 0, 0, 0, 0);

        for (int i = 0; i < 7; i++) send(i, 1, (i == 6));
        recv("g_full", 7'h7F, 7, 0, 0);

        send(4, 1, 0); send(2, 1, 1);
        recv("g_order", 7'h14, 2, 1, 0);
        send(3, 1, 1);
        recv("g_noleak", 7'h08, 1, 0, 0);

        send(7, 1, 0); send(5, 1, 1);
        recv("g_range", 7'h20, 1, 1, 0);

        send(3, 1, 0); send(3, 1, 1);
        recv("g_dup", 7'h08, 1, 1, 0);

        send(2, 1, 0); send(0, 0, 0); send(5, 1, 1);
        recv("g_bp", 7'h24, 2, 0, 5);
        send(0, 1, 1);
        recv("g_after_bp", 7'h01, 1, 0, 0);

        send(2, 1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_mask", int'(out_mask), 0);
        chk("midrst_out_cnt", int'(out_cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(3, 1, 1);
        recv("g_post_rst", 7'h08, 1, 0, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
